// File: rtl/dot_acc_pkg.sv
// Shared definitions for the dot-product accumulator slice.
// Holds the FSM state type, default format widths and signed-saturation
// limit helpers used by the accumulator top and its output converter.
package dot_acc_pkg;

    localparam int unsigned INT_BITS_DEF   = 7;
    localparam int unsigned FRAC_BITS_DEF  = 9;
    localparam int unsigned GUARD_BITS_DEF = 4;
    localparam int unsigned W_DEF          = INT_BITS_DEF + FRAC_BITS_DEF;
    localparam int unsigned PW_DEF         = 2 * W_DEF;
    localparam int unsigned CNT_W          = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Largest value of a w-bit two's-complement number (w <= 63).
    function automatic longint smax(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest value of a w-bit two's-complement number (w <= 63).
    function automatic longint smin(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/dot_accumulator_if.sv
// Handshake bundle for dot_accumulator: product input stream and
// result output stream.
//   master: producer/consumer side (drives in_*, out_ready)
//   slave : accumulator side (drives in_ready, out_*)
interface dot_accumulator_if
    import dot_acc_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned PW = PW_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [PW-1:0]    in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic             out_sat;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_count
    );
endinterface

// File: rtl/acc_round_sat.sv
// Combinational ACC_W -> W conversion: drops FRAC_BITS fraction bits
// (Q(2I).(2F) -> Q(I).(F)) and saturates to W-bit signed.
// Build option DOT_ACC_ROUND_EN: round half-up before the shift;
// otherwise plain arithmetic shift (truncate toward minus infinity).
// Ports:
//   acc  in  ACC_W  signed accumulator value
//   res  out W      converted, saturated result
//   clip out 1      result was saturated
module acc_round_sat
    import dot_acc_pkg::*;
#(
    parameter int unsigned ACC_W     = 36,
    parameter int unsigned W         = 16,
    parameter int unsigned FRAC_BITS = 9
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [W-1:0]     res,
    output logic                    clip
);
    localparam int unsigned EW = ACC_W + 1;
`ifdef DOT_ACC_ROUND_EN
    localparam logic [EW-1:0] HALF = EW'(1) << (FRAC_BITS - 1);
`endif

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] shifted;
    longint               val;

    // One extra bit keeps the rounding add from wrapping.
    always_comb begin
        ext = {acc[ACC_W-1], acc};
`ifdef DOT_ACC_ROUND_EN
        ext = ext + $signed(HALF);
`endif
        shifted = ext >>> FRAC_BITS;
        val     = 64'(shifted);
        clip    = 1'b0;
        res     = W'(shifted);
        if (val > smax(W)) begin
            res  = W'(smax(W));
            clip = 1'b1;
        end else if (val < smin(W)) begin
            res  = W'(smin(W));
            clip = 1'b1;
        end
    end

endmodule

// File: rtl/dot_accumulator.sv
// Streaming dot-product accumulator. Sums signed Q(2I).(2F) products of
// one in_last-terminated vector in a guarded, saturating accumulator and
// presents the rounded/saturated Q(I).(F) total on a valid/ready port.
// Build option DOT_ACC_ROUND_EN selects round half-up in the converter.
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave side of dot_accumulator_if
//          (in_valid/in_ready/in_data/in_last,
//           out_valid/out_ready/out_data/out_sat/out_count)
module dot_accumulator
    import dot_acc_pkg::*;
#(
    parameter int unsigned INT_BITS   = INT_BITS_DEF,
    parameter int unsigned FRAC_BITS  = FRAC_BITS_DEF,
    parameter int unsigned GUARD_BITS = GUARD_BITS_DEF
) (
    input logic               clk,
    input logic               rst_n,
    dot_accumulator_if.slave  bus
);
    localparam int unsigned W     = INT_BITS + FRAC_BITS;
    localparam int unsigned PW    = 2 * W;
    localparam int unsigned ACC_W = PW + GUARD_BITS;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_new;
    logic [CNT_W-1:0]        count_q, count_d, count_new;
    logic                    sticky_q, sticky_d, sticky_new;
    logic                    out_valid_q, out_valid_d;
    logic [W-1:0]            out_data_q, out_data_d;
    logic                    out_sat_q, out_sat_d;
    logic [CNT_W-1:0]        out_count_q, out_count_d;

    logic                    in_ready_c;
    logic                    accept_c;
    logic signed [ACC_W-1:0] in_sext;
    logic signed [ACC_W:0]   sum;
    logic                    acc_clip;
    logic [W-1:0]            conv_res;
    logic                    conv_clip;

    assign in_ready_c = !out_valid_q || bus.out_ready;
    assign accept_c   = bus.in_valid && in_ready_c;
    assign in_sext    = {{GUARD_BITS{bus.in_data[PW-1]}}, bus.in_data};

    // Accumulator value an accepted beat would produce.
    always_comb begin
        sum        = {acc_q[ACC_W-1], acc_q} + {in_sext[ACC_W-1], in_sext};
        acc_clip   = sum[ACC_W] ^ sum[ACC_W-1];
        acc_new    = in_sext;
        count_new  = CNT_W'(1);
        sticky_new = 1'b0;
        if (state_q == ACCUM) begin
            if (acc_clip) begin
                acc_new = sum[ACC_W] ? ACC_MIN : ACC_MAX;
            end else begin
                acc_new = sum[ACC_W-1:0];
            end
            count_new  = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_W'(1);
            sticky_new = sticky_q | acc_clip;
        end
    end

    // Converter sees the post-beat total so the last beat is included.
    acc_round_sat #(
        .ACC_W     (ACC_W),
        .W         (W),
        .FRAC_BITS (FRAC_BITS)
    ) u_conv (
        .acc  (acc_new),
        .res  (conv_res),
        .clip (conv_clip)
    );

    // Next-state and output-register logic.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_count_d = out_count_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept_c) begin
            acc_d    = acc_new;
            count_d  = count_new;
            sticky_d = sticky_new;
            if (bus.in_last) begin
                state_d     = DONE;
                out_valid_d = 1'b1;
                out_data_d  = conv_res;
                out_sat_d   = sticky_new | conv_clip;
                out_count_d = count_new;
            end else begin
                state_d = ACCUM;
            end
        end else if (state_q == DONE && bus.out_ready) begin
            state_d  = IDLE;
            acc_d    = '0;
            count_d  = '0;
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_count_q <= out_count_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_dot_accumulator.sv
// Directed bench for dot_accumulator: table of vectors with hand-computed
// results plus sequences for saturation, backpressure and mid-vector reset.
module tb_dot_accumulator;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    dot_accumulator_if bus ();

    dot_accumulator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DOT_ACC_ROUND_EN
    localparam logic [15:0] EXP_0100 = 16'h0001;
    localparam logic [15:0] EXP_NEG  = 16'h0000;
`else
    localparam logic [15:0] EXP_0100 = 16'h0000;
    localparam logic [15:0] EXP_NEG  = 16'hFFFF;
`endif

    typedef struct {
        int          n;
        logic [31:0] beats [4];
        logic [15:0] exp_data;
        logic        exp_sat;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input int n, input logic [31:0] b0, input logic [31:0] b1,
                                input logic [31:0] b2, input logic [31:0] b3,
                                input logic [15:0] d, input logic s, input logic [7:0] c);
        vec_t v;
        v.n        = n;
        v.beats[0] = b0;
        v.beats[1] = b1;
        v.beats[2] = b2;
        v.beats[3] = b3;
        v.exp_data = d;
        v.exp_sat  = s;
        v.exp_cnt  = c;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one beat, wait (bounded) for in_ready, let it be accepted.
    task automatic send_beat(input logic [31:0] d, input logic last);
        int t;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 50) begin
            errors++;
            $display("FAIL handshake_timeout: in_ready low for %0d cycles, required high", t);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [15:0] d, input logic s,
                                input logic [7:0] c);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'(1'b1));
        check({tag, "_data"},  32'(bus.out_data),  32'(d));
        check({tag, "_sat"},   32'(bus.out_sat),   32'(s));
        check({tag, "_count"}, 32'(bus.out_count), 32'(c));
    endtask

    initial begin
        int seen;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        vecs[0] = mk(3, 32'h0004_0000, 32'h0002_0000, 32'hFFFE_0000, 32'h0, 16'h0200, 1'b0, 8'd3);
        vecs[1] = mk(1, 32'h0000_0100, 32'h0, 32'h0, 32'h0, EXP_0100, 1'b0, 8'd1);
        vecs[2] = mk(1, 32'h0000_00FF, 32'h0, 32'h0, 32'h0, 16'h0000, 1'b0, 8'd1);
        vecs[3] = mk(4, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                     16'h7FFF, 1'b1, 8'd4);
        vecs[4] = mk(1, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 16'h8000, 1'b1, 8'd1);
        vecs[5] = mk(1, 32'hFFFF_FF00, 32'h0, 32'h0, 32'h0, EXP_NEG, 1'b0, 8'd1);
        vecs[6] = mk(2, 32'h0000_0200, 32'h0000_0200, 32'h0, 32'h0, 16'h0002, 1'b0, 8'd2);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'(1'b0));
        check("rst_out_data",  32'(bus.out_data),  32'h0);
        check("rst_in_ready",  32'(bus.in_ready),  32'(1'b1));
        check("rst_out_sat",   32'(bus.out_sat),   32'(1'b0));
        check("rst_out_count", 32'(bus.out_count), 32'h0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("idle_no_output", 32'(seen), 32'h0);

        // Table vectors, back-to-back with out_ready high
        for (int v = 0; v < 7; v++) begin
            for (int b = 0; b < vecs[v].n; b++) begin
                send_beat(vecs[v].beats[b], b == vecs[v].n - 1);
            end
            check_result($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_sat,
                         vecs[v].exp_cnt);
        end

        // Twenty max beats: accumulator clips
        for (int i = 0; i < 20; i++) begin
            send_beat(32'h7FFF_FFFF, i == 19);
        end
        check_result("acc_clip20", 16'h7FFF, 1'b1, 8'd20);
        @(negedge clk);
        check("drain_valid", 32'(bus.out_valid), 32'(1'b0));

        // Backpressure: result held, input stalled
        bus.out_ready = 1'b0;
        send_beat(32'h0004_0000, 1'b0);
        send_beat(32'h0004_0000, 1'b1);
        check_result("bp_first", 16'h0400, 1'b0, 8'd2);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h0004_0000;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(bus.in_ready),  32'(1'b0));
            check("bp_valid",    32'(bus.out_valid), 32'(1'b1));
            check("bp_data",     32'(bus.out_data),  32'h0400);
            check("bp_count",    32'(bus.out_count), 32'd2);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check_result("bp_second", 16'h0200, 1'b0, 8'd1);
        @(negedge clk);
        check("bp_drain_valid", 32'(bus.out_valid), 32'(1'b0));

        // Reset mid-vector discards the partial sum
        send_beat(32'h0004_0000, 1'b0);
        send_beat(32'h0004_0000, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(bus.out_valid), 32'(1'b0));
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("midrst_no_output", 32'(seen), 32'h0);
        send_beat(32'h0004_0000, 1'b1);
        check_result("after_rst", 16'h0200, 1'b0, 8'd1);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dot_accumulator.md
# dot_accumulator

Streaming accumulator that sits directly downstream of the fixed-point product/sum datapath. It consumes a stream of signed double-width products in Q(2·INT).(2·FRAC) format and sums one vector per `in_last`-terminated burst in a guarded accumulator. At the end of each vector it rounds and saturates the total back to the single-width Q(INT).(FRAC) format and presents it on a valid/ready output port.

## Interface
- `INT_BITS`, 7, integer bits of the single-width format.
- `FRAC_BITS`, 9, fraction bits of the single-width format.
- `GUARD_BITS`, 4, accumulator headroom above the product width.
- Derived: W = INT_BITS+FRAC_BITS (16); PW = 2·W (32); ACC_W = PW+GUARD_BITS (36).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when high together with `in_valid`.
- `in_data`  in  PW  signed product, Q(2·INT).(2·FRAC).
- `in_last`  in  1  marks the final beat of a vector.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  W  signed result, Q(INT).(FRAC).
- `out_sat`  out  1  result was clipped, either in the accumulator or in the output conversion.
- `out_count`  out  8  number of beats in the vector; saturates at 255.

## Operation
- FSM states:
  - IDLE: accumulator empty.
  - ACCUM: partial sum held.
  - DONE: result held on the output.
- Input handshake: accept when `in_valid && in_ready`, with `in_ready = !out_valid || out_ready`.
- Accepted beat in IDLE or DONE:
  - acc <= sext(in_data); count <= 1; sticky <= 0.
  - Next state is ACCUM, or DONE if `in_last`.
- Accepted beat in ACCUM:
  - acc <= sat_ACC_W(acc + sext(in_data)); count <= min(count+1, 255).
  - sticky |= accumulator clip.
- Accepted beat with `in_last`: the converted result is registered to `out_data`/`out_sat`/`out_count`, and `out_valid` is set.
- DONE with `out_ready` and no accepted beat: `out_valid` clears and the FSM returns to IDLE.
- DONE with `out_ready` and an accepted beat in the same cycle: the output handshake completes and the beat starts a fresh vector.
- Output conversion:
  - Arithmetic right shift of acc by FRAC_BITS (from 2·FRAC to FRAC fraction bits), with optional rounding (see Configuration).
  - Saturate to W bits signed: 0x7FFF max, 0x8000 min at defaults.
  - `out_sat` = sticky OR conversion clip.
- `in_valid` low keeps the current state; bubbles are allowed mid-vector.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_sat`=0, `out_count`=0, `in_ready`=1, FSM=IDLE, acc=0, count=0, sticky=0.
- Reset asserted mid-vector discards the partial sum with no output.
- Latency: `out_valid` rises on the clock edge that accepts the `in_last` beat, so the result is visible the cycle after the last beat.
- Throughput: one beat per cycle. A back-to-back vector costs no bubble when `out_ready` is held high.
- While `out_valid && !out_ready`: `out_data`, `out_sat` and `out_count` stay stable and `in_ready`=0.
- A single-beat vector (`in_last` on the first beat) is legal.
- `in_ready` is combinational from `out_ready`. No other input-to-output combinational path is allowed.

## Configuration
- `DOT_ACC_ROUND_EN` defined: round half-up. Add 2^(FRAC_BITS-1) to acc, in ACC_W+1 bits, before the shift.
- `DOT_ACC_ROUND_EN` undefined: truncate toward −∞ (plain arithmetic shift).

## Structure
- Shared package `dot_acc_pkg` holds:
  - The FSM state enum (IDLE, ACCUM, DONE).
  - Default width constants.
  - Signed-saturation limit functions.
- One sub-module, `acc_round_sat`: purely combinational ACC_W → W round/shift/saturate, with a clip flag output. The top-level FSM instantiates it once.

## Test plan
- Reset: hold `rst_n`=0 → `out_valid`=0, `out_data`=0x0000, `in_ready`=1; release and idle 10 cycles → no output.
- Beats 0x00040000, 0x00020000, 0xFFFE0000 (last) → next cycle `out_data`=0x0200, `out_sat`=0, `out_count`=3.
- Single beat 0x00000100 (last) → 0x0001 with `DOT_ACC_ROUND_EN`, 0x0000 without. Single beat 0x000000FF → 0x0000 in both builds.
- Saturation:
  - Four beats of 0x7FFFFFFF → `out_data`=0x7FFF, `out_sat`=1.
  - Single beat 0x80000000 → 0x8000, `out_sat`=1.
  - Twenty beats of 0x7FFFFFFF → accumulator clips, `out_sat`=1, `out_count`=20.
- Backpressure: hold `out_ready`=0 for 5 cycles after a result → outputs stable, `in_ready`=0, pending beat stalled. Raise `out_ready` with `in_valid` → result consumed and beat 0x00040000 (last) yields 0x0200 the next cycle.
- Reset mid-vector: two beats accepted, pulse `rst_n` low → `out_valid` stays 0. Then single beat 0x00040000 (last) → 0x0200, `out_count`=1.
